pc_fetch_unit: RTL

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/pc_fetch_unit_if.sv | 42 ++++
 rtl/pc_fetch_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, reset address and state encoding for the fetch unit
// Contents:
//   AddrWidth / InstrWidth : address and instruction widths
//   DefaultResetPc         : default first fetch address
//   fetch_state_e          : 2-bit fetch FSM encoding
//   align_pc()             : clears the two byte-offset bits of an address
package fetch_pkg;

    localparam int AddrWidth  = 64;
    localparam int InstrWidth = 32;
    localparam int CountWidth = 32;

    localparam logic [AddrWidth-1:0] DefaultResetPc = 64'h0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_HOLD  = 2'b10,
        ST_FAULT = 2'b11
    } fetch_state_e;

    function automatic logic [AddrWidth-1:0] align_pc(input logic [AddrWidth-1:0] pc);
        return {pc[AddrWidth-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction-memory and decode handshake bundle for the fetch unit
// Signals:
//   IMemReq/IMemAddr      : read request and address toward instruction memory
//   IMemAck/IMemData      : memory response strobe and returned word
//   Instruction/InstrValid: fetched word held for decode
//   InstrTaken/NextPC     : retire strobe and the address to fetch next
// Modports: master = fetch unit, slave = memory/core environment.
interface pc_fetch_unit_if;
    import fetch_pkg::*;

    logic                  IMemReq;
    logic [AddrWidth-1:0]  IMemAddr;
    logic                  IMemAck;
    logic [InstrWidth-1:0] IMemData;
    logic [InstrWidth-1:0] Instruction;
    logic                  InstrValid;
    logic                  InstrTaken;
    logic [AddrWidth-1:0]  NextPC;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemAck,
        input  IMemData,
        output Instruction,
        output InstrValid,
        input  InstrTaken,
        input  NextPC
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemAck,
        output IMemData,
        input  Instruction,
        input  InstrValid,
        output InstrTaken,
        output NextPC
    );

endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - single-outstanding instruction fetch FSM with PC register and retire counter
// Ports:
//   CLK, Reset    : clock, asynchronous active-high reset
//   bus (master)  : memory request/response and decode handshake
//   CurrentPC     : address being fetched or held for decode
//   FetchCount    : retired instruction count, wraps modulo 2^32
//   MisalignFault : sticky, set when a retire offers a non word-aligned NextPC
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [AddrWidth-1:0] ResetPC = DefaultResetPc
) (
    input  logic                  CLK,
    input  logic                  Reset,
    pc_fetch_unit_if.master       bus,
    output logic [AddrWidth-1:0]  CurrentPC,
    output logic [CountWidth-1:0] FetchCount,
    output logic                  MisalignFault
);

    localparam logic [AddrWidth-1:0] ResetPcAligned = align_pc(ResetPC);

    fetch_state_e          state_q, state_d;
    logic [AddrWidth-1:0]  current_pc_q, current_pc_d;
    logic [InstrWidth-1:0] instruction_q, instruction_d;
    logic [CountWidth-1:0] fetch_count_q, fetch_count_d;
    logic                  misalign_q, misalign_d;
    logic                  imem_req_q, imem_req_d;
    logic                  instr_valid_q, instr_valid_d;

    always_comb begin
        state_d       = state_q;
        current_pc_d  = current_pc_q;
        instruction_d = instruction_q;
        fetch_count_d = fetch_count_q;
        misalign_d    = misalign_q;

        unique case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (bus.IMemAck) begin
                    instruction_d = bus.IMemData;
                    state_d       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.InstrTaken) begin
                    if (bus.NextPC[1:0] == 2'b00) begin
                        current_pc_d  = bus.NextPC;
                        fetch_count_d = fetch_count_q + 1'b1;
                        state_d       = ST_REQ;
                    end else begin
                        misalign_d = 1'b1;
                        state_d    = ST_FAULT;
                    end
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase

        // Request and valid are registered decodes of the next state, so they
        // line up exactly with the state they describe without a combinational path.
        imem_req_d    = (state_d == ST_REQ);
        instr_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            current_pc_q  <= ResetPcAligned;
            instruction_q <= '0;
            fetch_count_q <= '0;
            misalign_q    <= 1'b0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            current_pc_q  <= current_pc_d;
            instruction_q <= instruction_d;
            fetch_count_q <= fetch_count_d;
            misalign_q    <= misalign_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign bus.IMemReq     = imem_req_q;
    assign bus.IMemAddr    = current_pc_q;
    assign bus.Instruction = instruction_q;
    assign bus.InstrValid  = instr_valid_q;
    assign CurrentPC       = current_pc_q;
    assign FetchCount      = fetch_count_q;
    assign MisalignFault   = misalign_q;

endmodule
